// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared types and helpers for the parameterised register file.
//   - clr_state_t : state of the array-clear sweep controller
//   - even_par    : even-parity bit for a data word (zero-extended to 64 bits)
// ---------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // Parity bit that makes the XOR over {parity, data} equal zero.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// ---------------------------------------------------------------------------
// regfile_if
//   Bus bundle for regfile_param.
//   master : drives rd_addr, wr_en, wr_addr, wr_data, clr_req
//            receives rd_data, rd_perr, clr_busy, clr_done, wr_rej
//   slave  : the register file side (directions mirrored)
//   Read ports are packed: port i uses rd_addr[i*AW +: AW] and
//   rd_data[i*DATA_W +: DATA_W].
// ---------------------------------------------------------------------------
interface regfile_if #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 32,
    parameter int NRD    = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_perr;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  clr_done;
    logic                  wr_rej;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, rd_perr, clr_busy, clr_done, wr_rej
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, rd_perr, clr_busy, clr_done, wr_rej
    );

endinterface

// File: rtl/regfile_clr_fsm.sv
// ---------------------------------------------------------------------------
// regfile_clr_fsm
//   Sweep controller that zeroes every entry of the register file, one
//   entry per cycle, then reports completion for a single cycle.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     i_clr_req    : start a sweep (honoured only in IDLE)
//     o_idle       : controller is IDLE (writes may be accepted)
//     o_clr_en     : zero the entry at o_clr_addr on this edge
//     o_clr_addr   : entry being cleared
//     o_clr_busy   : high for exactly DEPTH cycles while sweeping
//     o_clr_done   : one-cycle pulse after the last entry is cleared
// ---------------------------------------------------------------------------
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr_req,
    output logic          o_idle,
    output logic          o_clr_en,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_clr_busy,
    output logic          o_clr_done
);

    clr_state_t    r_state;
    logic [AW-1:0] r_ptr;
    logic          r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_clr_req) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                    end
                end
                CLEAR: begin
                    if (r_ptr == AW'(DEPTH - 1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_idle     = (r_state == IDLE);
    assign o_clr_busy = (r_state == CLEAR);
    assign o_clr_en   = (r_state == CLEAR);
    assign o_clr_addr = r_ptr;
    assign o_clr_done = r_done;

endmodule

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//   Parameterised register file: NRD combinational read ports with
//   write-through bypass, one write port, and a full-array clear sweep.
//   Parameters: DATA_W (1..64), DEPTH (2..256), NRD (1..4), ZERO_REG0.
//   Ports:
//     clk   : single clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : regfile_if.slave (read/write/clear/status signals)
//   Build option: define REGFILE_PARITY_EN to store an even-parity bit
//   per entry and flag mismatches on rd_perr; otherwise rd_perr is 0.
// ---------------------------------------------------------------------------
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 19,
    parameter int DEPTH     = 32,
    parameter int NRD       = 2,
    parameter int ZERO_REG0 = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    regfile_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
`ifdef REGFILE_PARITY_EN
    localparam int EW = DATA_W + 1;
`else
    localparam int EW = DATA_W;
`endif

    logic [EW-1:0]         r_mem [DEPTH];
    logic                  r_wr_rej;

    logic                  w_idle;
    logic                  w_clr_en;
    logic [AW-1:0]         w_clr_addr;
    logic                  w_wr_inrange;
    logic                  w_wr_zero;
    logic                  w_wr_acc;
    logic                  w_wr_rej;
    logic [EW-1:0]         w_wr_word;
    logic [NRD*DATA_W-1:0] w_rd_data;
    logic [NRD-1:0]        w_rd_perr;

    regfile_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr_req  (bus.clr_req),
        .o_idle     (w_idle),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr),
        .o_clr_busy (bus.clr_busy),
        .o_clr_done (bus.clr_done)
    );

    assign w_wr_inrange = (int'(bus.wr_addr) < DEPTH);
    assign w_wr_zero    = (ZERO_REG0 != 0) && (bus.wr_addr == '0);
    assign w_wr_acc     = bus.wr_en && w_idle && w_wr_inrange && !w_wr_zero;
    // Register-0 writes are in range and dropped silently, so they never reject.
    assign w_wr_rej     = bus.wr_en && !(w_idle && w_wr_inrange);

`ifdef REGFILE_PARITY_EN
    assign w_wr_word = {even_par(64'(bus.wr_data)), bus.wr_data};
`else
    assign w_wr_word = bus.wr_data;
`endif

    // Clear and write never collide: a write is only accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_wr_rej <= 1'b0;
        end else begin
            r_wr_rej <= w_wr_rej;
            if (w_clr_en) begin
                r_mem[w_clr_addr] <= '0;
            end else if (w_wr_acc) begin
                r_mem[bus.wr_addr] <= w_wr_word;
            end
        end
    end

    always_comb begin : rd_mux
        logic [AW-1:0] ra;
        logic [EW-1:0] ent;
        w_rd_data = '0;
        w_rd_perr = '0;
        ra        = '0;
        ent       = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra = bus.rd_addr[i*AW +: AW];
            if ((ZERO_REG0 != 0) && (ra == '0)) begin
                w_rd_data[i*DATA_W +: DATA_W] = '0;
            end else if (w_wr_acc && (ra == bus.wr_addr)) begin
                w_rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
            end else if (int'(ra) < DEPTH) begin
                ent = r_mem[ra];
                w_rd_data[i*DATA_W +: DATA_W] = ent[DATA_W-1:0];
`ifdef REGFILE_PARITY_EN
                w_rd_perr[i] = ^ent;
`endif
            end
        end
    end

    assign bus.rd_data = w_rd_data;
    assign bus.rd_perr = w_rd_perr;
    assign bus.wr_rej  = r_wr_rej;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_if #(.DATA_W(19), .DEPTH(32), .NRD(2)) bus ();

    regfile_param #(
        .DATA_W    (19),
        .DEPTH     (32),
        .NRD       (2),
        .ZERO_REG0 (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: plain array plus a sweep position counter.
    // m_pos = -1 : no sweep; 0..31 : entry m_pos cleared this cycle; 32 : done cycle.
    logic [18:0] m_mem [32];
    int          m_pos;
    logic        m_rej;

    int n_chk = 0;
    int n_err = 0;
    int n_busy = 0;
    int n_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] exp_rd(input logic [4:0] ra, input bit idle,
                                          input logic we, input logic [4:0] wa,
                                          input logic [18:0] wd);
        if (ra == 5'd0) return 19'd0;
        if (idle && we && wa == ra) return wd;
        return m_mem[ra];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_mem[k] = 19'd0;
        m_pos = -1;
        m_rej = 1'b0;
    endtask

    // Called at posedge+1; checks mid-cycle, then advances one clock.
    task automatic do_cycle(input logic we, input logic [4:0] wa, input logic [18:0] wd,
                            input logic creq, input logic [4:0] ra0, input logic [4:0] ra1);
        bit idle;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.clr_req = creq;
        bus.rd_addr = {ra1, ra0};
        #4;
        idle = (m_pos < 0);
        chk("rd0",  64'(bus.rd_data[18:0]),  64'(exp_rd(ra0, idle, we, wa, wd)));
        chk("rd1",  64'(bus.rd_data[37:19]), 64'(exp_rd(ra1, idle, we, wa, wd)));
        chk("perr", 64'(bus.rd_perr), 64'd0);
        chk("busy", 64'(bus.clr_busy), 64'(m_pos >= 0 && m_pos < 32));
        chk("done", 64'(bus.clr_done), 64'(m_pos == 32));
        chk("rej",  64'(bus.wr_rej), 64'(m_rej));
        if (bus.clr_busy === 1'b1) n_busy++;
        if (bus.clr_done === 1'b1) n_done++;
        @(posedge clk);
        #1;
        if (idle && we && wa != 5'd0) m_mem[wa] = wd;
        if (m_pos >= 0 && m_pos < 32) m_mem[m_pos] = 19'd0;
        m_rej = we && !idle;
        if (idle) begin
            if (creq) m_pos = 0;
        end else begin
            m_pos++;
            if (m_pos > 32) m_pos = -1;
        end
    endtask

    task automatic idle_cycle();
        do_cycle(1'b0, 5'(22), 19'd0, 1'b0, 5'($urandom_range(31)), 5'($urandom_range(31)));
    endtask

    task automatic fill_all();
        for (int k = 0; k < 32; k++)
            do_cycle(1'b1, 5'(k), 19'($urandom), 1'b0, 5'($urandom_range(31)), 5'(k));
    endtask

    task automatic read_all();
        for (int k = 0; k < 32; k++)
            do_cycle(1'b0, 5'd0, 19'd0, 1'b0, 5'(k), 5'(31 - k));
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 32; k++)
            chk(tag, 64'(m_mem[k]), 64'd0);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.clr_req = 1'b0;
        bus.rd_addr = {5'd9, 5'd5};
        model_reset();

        // Reset state
        #3;
        chk("rst_rd0",  64'(bus.rd_data[18:0]),  64'd0);
        chk("rst_rd1",  64'(bus.rd_data[37:19]), 64'd0);
        chk("rst_busy", 64'(bus.clr_busy), 64'd0);
        chk("rst_done", 64'(bus.clr_done), 64'd0);
        chk("rst_rej",  64'(bus.wr_rej), 64'd0);
        chk("rst_perr", 64'(bus.rd_perr), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write 7, read on port 1 next cycle
        do_cycle(1'b1, 5'd7, 19'h5A5A5, 1'b0, 5'd1, 5'd2);
        do_cycle(1'b0, 5'd0, 19'd0, 1'b0, 5'd4, 5'd7);
        chk("rd7_direct", 64'(bus.rd_data[37:19]), 64'h5A5A5);

        // Same-cycle bypass on port 0
        bus.rd_addr = {5'd8, 5'd3};
        do_cycle(1'b1, 5'd3, 19'h12345, 1'b0, 5'd3, 5'd8);

        // Register 0 write dropped silently
        do_cycle(1'b1, 5'd0, 19'h7FFFF, 1'b0, 5'd0, 5'd0);
        do_cycle(1'b0, 5'd0, 19'd0, 1'b0, 5'd0, 5'd3);
        chk("r0_rej_direct", 64'(bus.wr_rej), 64'd0);

        // Random read/write traffic, no clears
        for (int n = 0; n < 200; n++)
            do_cycle(1'($urandom), 5'($urandom), 19'($urandom), 1'b0,
                     5'($urandom), 5'($urandom));

        // Fill then full sweep: 32 busy cycles, one done cycle, array zero
        fill_all();
        n_busy = 0; n_done = 0;
        do_cycle(1'b0, 5'd0, 19'd0, 1'b1, 5'd12, 5'd30);
        for (int n = 0; n < 36; n++) idle_cycle();
        chk("busy_len", 64'(n_busy), 64'd32);
        chk("done_cnt", 64'(n_done), 64'd1);
        check_all_zero("swept_model");
        read_all();

        // Write and clr_req together, then write at sweep cycle 5
        fill_all();
        do_cycle(1'b1, 5'd17, 19'h2AAAA, 1'b1, 5'd17, 5'd1);
        for (int n = 0; n < 5; n++) idle_cycle();
        do_cycle(1'b1, 5'd9, 19'h13579, 1'b0, 5'd9, 5'd2);
        chk("rej_during_clear", 64'(bus.wr_rej), 64'd1);
        for (int n = 0; n < 30; n++) idle_cycle();
        read_all();

        // Reset at sweep cycle 10 aborts with no done pulse
        fill_all();
        do_cycle(1'b0, 5'd0, 19'd0, 1'b1, 5'd4, 5'd5);
        for (int n = 0; n < 10; n++) idle_cycle();
        bus.wr_en   = 1'b0;
        bus.clr_req = 1'b0;
        bus.rd_addr = {5'd31, 5'd20};
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("mid_rst_rd0",  64'(bus.rd_data[18:0]),  64'd0);
        chk("mid_rst_rd1",  64'(bus.rd_data[37:19]), 64'd0);
        chk("mid_rst_busy", 64'(bus.clr_busy), 64'd0);
        chk("mid_rst_done", 64'(bus.clr_done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_done = 0;
        for (int n = 0; n < 40; n++) idle_cycle();
        chk("no_done_after_abort", 64'(n_done), 64'd0);
        read_all();

        // Random traffic with occasional clear requests
        for (int n = 0; n < 400; n++)
            do_cycle(1'($urandom), 5'($urandom), 19'($urandom),
                     1'($urandom_range(39) == 0), 5'($urandom), 5'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 19, SHALL set the register data width in bits (range 1..64).
REQ-002 Parameter DEPTH, default 32, SHALL set the number of registers (range 2..256); localparam AW = clog2(DEPTH).
REQ-003 Parameter NRD, default 2, SHALL set the number of read ports (range 1..4).
REQ-004 Parameter ZERO_REG0, default 1, SHALL make register 0 read as zero and ignore writes to it when 1.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 rd_addr  input  NRD*AW  SHALL carry the packed read addresses; port i uses bits [i*AW +: AW].
REQ-008 rd_data  output  NRD*DATA_W  SHALL carry the packed read data; port i uses bits [i*DATA_W +: DATA_W].
REQ-009 wr_en  input  1  SHALL request a write.
REQ-010 wr_addr  input  AW  SHALL give the write address.
REQ-011 wr_data  input  DATA_W  SHALL give the write data.
REQ-012 clr_req  input  1  SHALL request a full-array clear sweep.
REQ-013 clr_busy  output  1  SHALL be high while a clear sweep runs.
REQ-014 clr_done  output  1  SHALL pulse high for one cycle when a sweep completes.
REQ-015 wr_rej  output  1  SHALL pulse high in the cycle after a write is dropped.
REQ-016 rd_perr  output  NRD  SHALL flag a parity mismatch per read port (see Configuration).

Function
REQ-017 Reads SHALL be combinational, with zero-cycle latency from rd_addr to rd_data.
REQ-018 A write SHALL occur on the rising edge when wr_en=1, wr_addr<DEPTH, the FSM is IDLE, and the write is not suppressed by ZERO_REG0.
REQ-019 Write-through bypass: when wr_en=1, the FSM is IDLE, the write is accepted, and rd_addr[i]==wr_addr, rd_data[i] SHALL equal wr_data in the same cycle.
REQ-020 When ZERO_REG0=1, a read of address 0 SHALL return 0, including when a write to address 0 is pending.
REQ-021 A read with rd_addr>=DEPTH SHALL return 0.
REQ-022 A write with wr_addr>=DEPTH SHALL be dropped and SHALL raise wr_rej.
REQ-023 Any write while clr_busy=1 SHALL be dropped and SHALL raise wr_rej.
REQ-024 A write to address 0 with ZERO_REG0=1 SHALL be dropped silently, with no wr_rej.
REQ-025 FSM states SHALL be IDLE, CLEAR and DONE.
REQ-026 Transition IDLE->CLEAR SHALL occur when clr_req=1; the pointer SHALL load 0.
REQ-027 If clr_req=1 and wr_en=1 in the same IDLE cycle, the write SHALL complete and the sweep SHALL start the next cycle.
REQ-028 In CLEAR, the entry at the pointer SHALL be zeroed each cycle; at pointer DEPTH-1 the FSM SHALL go to DONE, otherwise the pointer SHALL increment.
REQ-029 DONE SHALL last exactly one cycle with clr_done=1, then return to IDLE.
REQ-030 clr_busy SHALL equal (state==CLEAR), so it is high for exactly DEPTH cycles.
REQ-031 clr_req SHALL be ignored in CLEAR and DONE.
REQ-032 Reads during CLEAR SHALL return the current array contents, with no bypass.

Reset
REQ-033 While rst_n=0, all entries, the FSM (IDLE), the pointer, clr_done, wr_rej and rd_perr state SHALL be zero.
REQ-034 Asserting rst_n mid-sweep SHALL abort the sweep; after release the FSM SHALL be IDLE and no clr_done SHALL be emitted.

Configuration
REQ-035 With REGFILE_PARITY_EN defined, each entry SHALL store DATA_W+1 bits, with even parity written on every write and clear.
REQ-036 With REGFILE_PARITY_EN defined, rd_perr[i] SHALL be high when the stored parity mismatches for an in-range, non-bypassed read.
REQ-037 Without REGFILE_PARITY_EN, entries SHALL be DATA_W bits wide and rd_perr SHALL be tied to 0.

Structure
REQ-038 Package regfile_pkg SHALL hold the FSM state enum (IDLE/CLEAR/DONE) and the parity helper function.
REQ-039 The clear FSM and pointer SHALL live in sub-module regfile_clr_fsm, which drives the clear enable, clear address, clr_busy and clr_done.

Verification
REQ-040 Write 0x5A5A5 to address 7, then read it on port 1 the next cycle -> rd_data[1]=0x5A5A5.
REQ-041 wr_en=1, wr_addr=3, wr_data=0x12345 and rd_addr[0]=3 in the same cycle -> rd_data[0]=0x12345 in that cycle.
REQ-042 ZERO_REG0=1: write 0x7FFFF to address 0 -> read of address 0 returns 0 and wr_rej stays 0.
REQ-043 Fill all 32 entries, pulse clr_req -> clr_busy high for 32 cycles, then clr_done high for 1 cycle, then all reads return 0.
REQ-044 Write during clear at cycle 5 -> wr_rej=1 the next cycle and the array stays 0 after the sweep.
REQ-045 Drop rst_n at sweep cycle 10 -> all entries 0, FSM IDLE, and no clr_done pulse.
